// File: rtl/nco_sine_gen_pkg.sv
// nco_pkg: shared constants for the multi-channel NCO.
//   - Default widths for the accumulator, the quarter-wave table and the samples.
//   - Quadrant bit positions used when folding a full-turn phase onto the quarter table.
//   - Seed and tap mask of the optional dither LFSR (build macro NCO_DITHER_EN).
//   - State type for the configuration handshake.
package nco_pkg;

    localparam int NCO_PHASE_W = 32;
    localparam int NCO_LUT_AW  = 8;
    localparam int NCO_OUT_W   = 16;

    // Quadrant bit 0 mirrors the table index, and quadrant bit 1 negates the magnitude.
    localparam int QUAD_MIRROR_BIT = 0;
    localparam int QUAD_NEGATE_BIT = 1;

    // 16-bit Fibonacci LFSR with taps 16,14,13,11. These are bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        CFG_IDLE,
        CFG_BUSY
    } cfg_state_e;

endpackage

// File: rtl/nco_sine_gen_rom.sv
// sine_quarter_rom: synchronous-read quarter-wave sine table.
//   Entry j = round((2^(OUT_W-1)-1) * sin((j+0.5)*pi/2^(LUT_AW+1))).
//   The half-step offset makes mirrored addresses land exactly on the other half of the wave.
// Ports:
//   clk    - rising-edge clock
//   en_i   - read enable. The output register holds its value while this is low.
//   addr_i - table address
//   data_o - unsigned magnitude, registered one cycle after addr_i
module sine_quarter_rom #(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [OUT_W-1:0]  data_o
);

    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;

    // The table is computed at elaboration time. Every entry is strictly positive, so rounding up from +0.5 is enough.
    function automatic int sineEntry(input int j);
        real amp;
        real angle;
        amp   = real'((2 ** (OUT_W - 1)) - 1);
        angle = (real'(j) + 0.5) * PI / real'(2 ** (LUT_AW + 1));
        return $rtoi(amp * $sin(angle) + 0.5);
    endfunction

    logic [OUT_W-1:0] tableWord [DEPTH];
    logic [OUT_W-1:0] data_q;

    for (genvar j = 0; j < DEPTH; j++) begin : gen_entry
        localparam logic [OUT_W-1:0] ENTRY = OUT_W'(sineEntry(j));
        assign tableWord[j] = ENTRY;
    end

    // The read register has no reset. Downstream logic ignores it until the pipeline valid bits say it is meaningful.
    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= tableWord[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/nco_sine_gen.sv
// nco_sine_gen: multi-channel numerically controlled sine oscillator.
//   A single phase accumulator advances by the frequency control word on every enabled cycle.
//   Each channel adds its own phase offset to the truncated phase.
//   The result is folded onto a quarter-wave table and sign-corrected.
//   Build macro NCO_DITHER_EN adds LFSR phase dither ahead of truncation. The default build has no dither.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   en         - advances the accumulator and the 3-stage sample pipeline
//   sync_clr   - clears the accumulator on the next edge, regardless of en
//   cfg_valid  - configuration request
//   cfg_ready  - configuration can be accepted. Low for one cycle after each accept.
//   cfg_fcw    - frequency control word
//   cfg_phase  - per-channel phase offsets, with channel 0 in the LSBs
//   wave_out   - signed samples, with channel 0 in the LSBs
//   wave_valid - wave_out holds a new sample this cycle
module nco_sine_gen
    import nco_pkg::*;
#(
    parameter int PHASE_W = NCO_PHASE_W,
    parameter int LUT_AW  = NCO_LUT_AW,
    parameter int OUT_W   = NCO_OUT_W,
    parameter int NUM_CH  = 2,
    parameter int POFF_W  = LUT_AW + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     sync_clr,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PHASE_W-1:0]       cfg_fcw,
    input  logic [NUM_CH*POFF_W-1:0] cfg_phase,
    output logic [NUM_CH*OUT_W-1:0]  wave_out,
    output logic                     wave_valid
);

    cfg_state_e                cfgState_q, cfgState_d;
    logic                      cfgAccept;
    logic [PHASE_W-1:0]        acc_q, acc_d;
    logic [PHASE_W-1:0]        fcw_q;
    logic [NUM_CH*POFF_W-1:0]  off_q;
    logic [POFF_W-1:0]         truncPhase;
    logic                      v1_q, v2_q, waveValid_q;

    assign cfgAccept = cfg_valid && cfg_ready;
    assign cfg_ready = (cfgState_q == CFG_IDLE);

    // After an accept, the handshake is busy for exactly one cycle. Requests during that cycle are ignored.
    always_comb begin
        cfgState_d = cfgState_q;
        case (cfgState_q)
            CFG_IDLE: if (cfg_valid) cfgState_d = CFG_BUSY;
            CFG_BUSY: cfgState_d = CFG_IDLE;
            default:  cfgState_d = CFG_IDLE;
        endcase
    end

    // A clear takes priority over accumulation. A config never touches the accumulator, which keeps a retune phase-continuous.
    always_comb begin
        acc_d = acc_q;
        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + fcw_q;
        end
    end

    // Control state. A newly captured fcw only affects accumulator updates after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfgState_q <= CFG_IDLE;
            acc_q      <= '0;
            fcw_q      <= '0;
            off_q      <= '0;
        end else begin
            cfgState_q <= cfgState_d;
            acc_q      <= acc_d;
            if (cfgAccept) begin
                fcw_q <= cfg_fcw;
                off_q <= cfg_phase;
            end
        end
    end

`ifdef NCO_DITHER_EN
    logic [15:0]        lfsr_q;
    logic               lfsrFeedback;
    logic [PHASE_W-1:0] ditherMask;
    logic [PHASE_W-1:0] ditheredAcc;

    assign lfsrFeedback = ^(lfsr_q & LFSR_TAPS);
    assign ditherMask   = {{POFF_W{1'b0}}, {(PHASE_W - POFF_W){1'b1}}};
    assign ditheredAcc  = acc_q + (PHASE_W'(lfsr_q) & ditherMask);
    assign truncPhase   = ditheredAcc[PHASE_W-1 -: POFF_W];

    // The dither source steps in lockstep with the pipeline, so latency is unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[14:0], lfsrFeedback};
        end
    end
`else
    assign truncPhase = acc_q[PHASE_W-1 -: POFF_W];
`endif

    // Valid bits track which stages hold real data. The output valid strobe only lasts one enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            waveValid_q <= 1'b0;
        end else if (en) begin
            v1_q        <= 1'b1;
            v2_q        <= v1_q;
            waveValid_q <= v2_q;
        end else begin
            waveValid_q <= 1'b0;
        end
    end

    assign wave_valid = waveValid_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
        logic [POFF_W-1:0] phaseSum;
        logic [1:0]        quadrant;
        logic [LUT_AW-1:0] tableIdx;
        logic [LUT_AW-1:0] addr_d, addr_q;
        logic              neg1_q, neg2_q;
        logic [OUT_W-1:0]  romData;
        logic [OUT_W-1:0]  wave_d, wave_q;

        assign phaseSum = truncPhase + off_q[ch*POFF_W +: POFF_W];
        assign quadrant = phaseSum[POFF_W-1 -: 2];
        assign tableIdx = phaseSum[LUT_AW-1:0];
        assign addr_d   = quadrant[QUAD_MIRROR_BIT] ? ~tableIdx : tableIdx;

        // S1 stores the folded address. The negate flag travels alongside the ROM read so it lines up at S3.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                addr_q <= '0;
                neg1_q <= 1'b0;
                neg2_q <= 1'b0;
            end else if (en) begin
                addr_q <= addr_d;
                neg1_q <= quadrant[QUAD_NEGATE_BIT];
                neg2_q <= neg1_q;
            end
        end

        sine_quarter_rom #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) u_rom (
            .clk    (clk),
            .en_i   (en),
            .addr_i (addr_q),
            .data_o (romData)
        );

        assign wave_d = neg2_q ? (OUT_W'(0) - romData) : romData;

        // The output only loads once S2 holds real data. Partly filled pipeline contents never reach wave_out.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wave_q <= '0;
            end else if (en && v2_q) begin
                wave_q <= wave_d;
            end
        end

        assign wave_out[ch*OUT_W +: OUT_W] = wave_q;
    end

endmodule

// File: doc/nco_sine_gen.md
# nco_sine_gen

Parametrised multi-channel numerically controlled oscillator that replaces the fixed-rate `sine_gen`. It produces phase-continuous signed sine samples for the modulator datapath, with a runtime-programmable frequency control word and a per-channel phase offset. Each channel reads a shared quarter-wave table. One shared phase accumulator feeds `NUM_CH` offset taps. Outputs go to the mapper/modulator stage downstream.

## Interface
- `PHASE_W`, 32: accumulator width. Output frequency = fcw·f_clk/2^PHASE_W.
- `LUT_AW`, 8: quarter-wave table address width (2^LUT_AW entries).
- `OUT_W`, 16: signed sample width.
- `NUM_CH`, 2: number of phase-offset output channels.
- `POFF_W`, LUT_AW+2: per-channel phase offset width (one full turn = 2^POFF_W).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: advance accumulator and pipeline.
- `sync_clr` in 1: synchronous accumulator clear.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: configuration can be accepted.
- `cfg_fcw` in PHASE_W: frequency control word.
- `cfg_phase` in NUM_CH·POFF_W: per-channel offsets, channel 0 in the LSBs.
- `wave_out` out NUM_CH·OUT_W: signed two's-complement samples, channel 0 in the LSBs.
- `wave_valid` out 1: `wave_out` holds a new sample this cycle.

## Operation
- Reset (`reset`=0) forces the following, all asynchronously:
  - acc=0, fcw=0, offsets=0.
  - `wave_out`=0, `wave_valid`=0.
  - `cfg_ready`=1.
  - Pipeline valid bits=0.
- Config handshake:
  - A config is accepted when `cfg_valid && cfg_ready`. `cfg_fcw` and `cfg_phase` are registered on that edge.
  - `cfg_ready` drops for exactly the next cycle, then returns to 1.
  - `cfg_valid` held high during that cycle is ignored.
- Accumulator: when `en`=1, acc ← (acc + fcw) mod 2^PHASE_W. Wrap-around is silent.
- Retune is phase-continuous. The new fcw applies from the first accumulator update after acceptance, and acc is never reset by a config.
- `sync_clr`=1 sets acc=0 on the next edge regardless of `en`. When a config is accepted on the same edge, the clear still wins for acc and the config is still captured.
- `en`=0 freezes acc and all pipeline registers. `wave_out` holds its value and `wave_valid`=0.
- Per-channel phase:
  - p_k = acc[PHASE_W-1 -: POFF_W] + off_k, mod 2^POFF_W.
  - The quadrant is q = p_k[POFF_W-1:POFF_W-2]. The index is i = p_k[LUT_AW-1:0].
  - The table address is i when q[0]=0, and ~i when q[0]=1.
  - The looked-up magnitude is negated when q[1]=1.
- Table contents: entry j = round((2^(OUT_W-1)-1)·sin((j+0.5)·π/2^(LUT_AW+1))).
  - The half-step offset makes the quadrant folding exact.
  - No entry is 0 or needs saturation, so negation never overflows.

## Timing
- Pipeline depth is 3, all stages enabled by `en`:
  - S1: offset add, fold, address register.
  - S2: ROM read.
  - S3: conditional negate, output register.
- A sample reflects the acc value that was current 3 enabled cycles earlier.
- `wave_valid` first asserts on the 3rd rising edge after `en` rises following reset. After that it equals `en` while the pipeline is full.
- A new offset is seen at S1 on the cycle after acceptance, so it reaches `wave_out` 3 enabled cycles later.
- Reset asserted mid-stream clears everything within the same cycle, with no partial output.

## Configuration
- `NCO_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances on each enabled cycle.
  - Its low (PHASE_W−POFF_W) bits are added to the truncated phase before slicing, which spreads the truncation spurs.
  - Pipeline latency is unchanged.
- `NCO_DITHER_EN` not defined: the phase is truncated directly and no LFSR logic exists. Output is fully deterministic; the test plan values assume this build.

## Structure
- Package `nco_pkg` holds:
  - Default parameter constants (`NCO_PHASE_W`, `NCO_LUT_AW`, `NCO_OUT_W`).
  - The quadrant encoding constants.
  - The LFSR seed and tap constants.
- Sub-module `sine_quarter_rom`:
  - Synchronous-read quarter-wave ROM with parameters `LUT_AW` and `OUT_W`, initialised by a generate loop or `$readmemh`.
  - It is instantiated once per channel and shares the same contents.

## Test plan
- Reset/idle: assert `reset`=0 mid-run → `wave_out`=0, `wave_valid`=0, `cfg_ready`=1 in the same cycle; after release, acc=0.
- Basic tone:
  - Stimulus: fcw=2^24 (period 256 clk), offsets 0, `en`=1.
  - `wave_valid` rises on the 3rd edge and the first ch0 sample is +101.
  - The sample at phase index 64 is +32767 and at index 192 is −32767.
  - Period is exactly 256.
- Quadrature: ch1 offset=256 (quarter turn) → ch1 first sample 32767, and ch1[n] = ch0[n+64] for all n.
- Phase-continuous retune: switch fcw 2^24→2^25 at acc=0x40000000 → next acc=0x42000000, with no glitch or jump in `wave_out` beyond one step.
- Clear/config collision: `sync_clr`=1 together with an accepted config (fcw=2^26) → acc=0 next cycle, the next increment is 2^26, and `cfg_ready` is low for one cycle.
- Edge FCWs:
  - fcw=0 → constant +101 forever.
  - fcw=2^31 → alternates +101/−101.
  - `en`=0 for 10 cycles → output held and `wave_valid`=0, then the sequence resumes without a skipped sample.
